// File: rtl/video_cap_pkg.sv
// video_cap_pkg: shared FSM encoding and default geometry for video line capture
package video_cap_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE} state_t;
    localparam int CAP_ADDR_WIDTH = 11;
    localparam int CAP_HACTIVE    = 640;
    localparam int CAP_VACTIVE    = 480;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: registered rise/fall detector for a level signal
// Ports: clk, rst (sync, active-high); d level input; rise/fall strobes in the cycle d changes.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic q;
    always_ff @(posedge clk) q <= rst ? 1'b0 : d;
    assign rise = d & ~q;
    assign fall = ~d & q;
endmodule

// File: rtl/video_line_capture.sv
// video_line_capture: binarizes camera video and hands each active line to the line-memory writer
// Ports: VCLK, RST (sync, active-high); iVSYNC/iHSYNC/iDE/iPIX/iTHRESH raw video in;
//   oH_ADDR/oV_ADDR current pixel address; oLINE_DATA/oLINE_NUM/oLINE_VALID with iLINE_READY
//   form the line handshake (bit h = column h); oFRAME_START frame pulse; oOVERRUN sticky drop flag.
// Define VIDEO_CAP_PIXCNT_EN to add oLINE_ONES, the set-bit count of the published line.
module video_line_capture
    import video_cap_pkg::*;
#(
    parameter int ADDR_WIDTH  = CAP_ADDR_WIDTH,
    parameter int HACTIVE     = CAP_HACTIVE,
    parameter int VACTIVE     = CAP_VACTIVE,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                   VCLK,
    input  logic                   RST,
    input  logic                   iVSYNC,
    input  logic                   iHSYNC,
    input  logic                   iDE,
    input  logic [PIXEL_WIDTH-1:0] iPIX,
    input  logic [PIXEL_WIDTH-1:0] iTHRESH,
    output logic [ADDR_WIDTH-1:0]  oH_ADDR,
    output logic [ADDR_WIDTH-1:0]  oV_ADDR,
    output logic [HACTIVE-1:0]     oLINE_DATA,
    output logic [ADDR_WIDTH-1:0]  oLINE_NUM,
    output logic                   oLINE_VALID,
    input  logic                   iLINE_READY,
    output logic                   oFRAME_START,
    output logic                   oOVERRUN
`ifdef VIDEO_CAP_PIXCNT_EN
    ,
    output logic [ADDR_WIDTH-1:0]  oLINE_ONES
`endif
);
    localparam logic [ADDR_WIDTH-1:0] H_MAX = ADDR_WIDTH'(HACTIVE);
    localparam logic [ADDR_WIDTH-1:0] V_MAX = ADDR_WIDTH'(VACTIVE);
    state_t                state;
    logic [ADDR_WIDTH-1:0] h;
    logic [HACTIVE-1:0]    line;
    logic                  vs_rise, vs_fall_unused, de_rise_unused, de_fall;
    logic                  line_end, take, load, drop, pix_bit;
    sync_edge_det u_vs (.clk(VCLK), .rst(RST), .d(iVSYNC), .rise(vs_rise), .fall(vs_fall_unused));
    sync_edge_det u_de (.clk(VCLK), .rst(RST), .d(iDE), .rise(de_rise_unused), .fall(de_fall));
    assign pix_bit  = iPIX >= iTHRESH;
    // A VSYNC rise wins over everything else in its cycle, so it masks line end and capture.
    assign line_end = !vs_rise && state == ACTIVE && de_fall;
    assign take     = !vs_rise && state != IDLE && iDE && h < H_MAX;
    // Lines past VACTIVE are neither published nor counted as overruns.
    assign load     = line_end && oV_ADDR < V_MAX && (!oLINE_VALID || iLINE_READY);
    assign drop     = line_end && oV_ADDR < V_MAX && !load;
    always_ff @(posedge VCLK) begin
        if (RST) begin
            state        <= IDLE;
            h            <= '0;
            line         <= '0;
            oH_ADDR      <= '0;
            oV_ADDR      <= '0;
            oLINE_DATA   <= '0;
            oLINE_NUM    <= '0;
            oLINE_VALID  <= 1'b0;
            oFRAME_START <= 1'b0;
            oOVERRUN     <= 1'b0;
        end else begin
            state        <= (vs_rise || line_end) ? WAIT_LINE : (state != IDLE && iDE) ? ACTIVE : state;
            h            <= (vs_rise || line_end) ? '0 : take ? h + ADDR_WIDTH'(1) : h;
            line         <= (vs_rise || line_end) ? '0 : take ? line | (HACTIVE'(pix_bit) << h) : line;
            oH_ADDR      <= (iHSYNC || !iDE) ? '0 : h;
            oV_ADDR      <= vs_rise ? '0 : (line_end && oV_ADDR < V_MAX) ? oV_ADDR + ADDR_WIDTH'(1) : oV_ADDR;
            oFRAME_START <= vs_rise;
            oOVERRUN     <= !vs_rise && (oOVERRUN || drop);
            oLINE_VALID  <= load || (oLINE_VALID && !iLINE_READY);
            if (load) begin
                oLINE_DATA <= line;
                oLINE_NUM  <= oV_ADDR;
            end
        end
    end
`ifdef VIDEO_CAP_PIXCNT_EN
    // Bounded by h, so it can never pass HACTIVE.
    logic [ADDR_WIDTH-1:0] ones;
    always_ff @(posedge VCLK) begin
        if (RST) begin
            ones       <= '0;
            oLINE_ONES <= '0;
        end else begin
            ones <= (vs_rise || line_end) ? '0 : (take && pix_bit) ? ones + ADDR_WIDTH'(1) : ones;
            if (load) oLINE_ONES <= ones;
        end
    end
`endif
endmodule

// File: tb/tb_video_line_capture.sv
// tb_video_line_capture: randomized self-checking bench for video_line_capture
module tb_video_line_capture;
    localparam int AW = 11, HA = 640, VA = 480, PW = 8;
    logic          VCLK = 1'b0, RST = 1'b1;
    logic          iVSYNC = 1'b0, iHSYNC = 1'b0, iDE = 1'b0, iLINE_READY = 1'b0;
    logic [PW-1:0] iPIX = '0, iTHRESH = '0;
    logic [AW-1:0] oH_ADDR, oV_ADDR, oLINE_NUM;
    logic [HA-1:0] oLINE_DATA;
    logic          oLINE_VALID, oFRAME_START, oOVERRUN;
`ifdef VIDEO_CAP_PIXCNT_EN
    logic [AW-1:0] oLINE_ONES;
`endif
    int            checks = 0, failures = 0;
    int            pix[700];
    int            thr;
    logic [HA-1:0] exp_word, saved_word;
    int            exp_ones;

    video_line_capture dut (
        .VCLK(VCLK), .RST(RST), .iVSYNC(iVSYNC), .iHSYNC(iHSYNC), .iDE(iDE),
        .iPIX(iPIX), .iTHRESH(iTHRESH), .oH_ADDR(oH_ADDR), .oV_ADDR(oV_ADDR),
        .oLINE_DATA(oLINE_DATA), .oLINE_NUM(oLINE_NUM), .oLINE_VALID(oLINE_VALID),
        .iLINE_READY(iLINE_READY), .oFRAME_START(oFRAME_START), .oOVERRUN(oOVERRUN)
`ifdef VIDEO_CAP_PIXCNT_EN
        , .oLINE_ONES(oLINE_ONES)
`endif
    );

    always #5 VCLK = ~VCLK;

    task automatic tick();
        @(posedge VCLK);
        #1;
    endtask

    // Reference: each captured column h < HACTIVE holds (pixel >= threshold), all else 0.
    task automatic model_line(input int n);
        exp_word = '0;
        exp_ones = 0;
        for (int i = 0; i < n && i < HA; i++)
            if (pix[i] >= thr) begin
                exp_word[i] = 1'b1;
                exp_ones++;
            end
    endtask

    task automatic rand_pixels(input int n);
        thr = $urandom_range(1, 255);
        for (int i = 0; i < n; i++) pix[i] = $urandom_range(0, 255);
    endtask

    // Drives one HSYNC pulse, n DE pixels, then the first DE-low edge (the publish edge).
    task automatic drive_line(input int n, input bit chk_h);
        int exp_h;
        model_line(n);
        iHSYNC = 1'b1;
        tick();
        iHSYNC = 1'b0;
        iTHRESH = PW'(thr);
        for (int i = 0; i < n; i++) begin
            iDE = 1'b1;
            iPIX = PW'(pix[i]);
            tick();
            if (chk_h && i == n - 1) begin
                exp_h = (i < HA) ? i : HA;
                checks++;
                if (oH_ADDR !== AW'(exp_h)) begin
                    failures++;
                    $display("FAIL h_addr_last got=%0d exp=%0d", oH_ADDR, exp_h);
                end
            end
        end
        iDE = 1'b0;
        tick();
    endtask

    task automatic frame_start();
        iVSYNC = 1'b1;
        tick();
        checks++;
        if (oFRAME_START !== 1'b1) begin
            failures++;
            $display("FAIL frame_start_pulse got=%0b exp=1", oFRAME_START);
        end
        iVSYNC = 1'b0;
        tick();
        checks++;
        if (oFRAME_START !== 1'b0) begin
            failures++;
            $display("FAIL frame_start_width got=%0b exp=0", oFRAME_START);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        checks++;
        if ({oH_ADDR, oV_ADDR, oLINE_NUM, oLINE_VALID, oFRAME_START, oOVERRUN} !== '0 || oLINE_DATA !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=h%0h/v%0h/n%0h/val%0b/fs%0b/ov%0b exp=0", oH_ADDR, oV_ADDR, oLINE_NUM, oLINE_VALID, oFRAME_START, oOVERRUN);
        end
`ifdef VIDEO_CAP_PIXCNT_EN
        checks++;
        if (oLINE_ONES !== '0) begin
            failures++;
            $display("FAIL reset_ones got=%0d exp=0", oLINE_ONES);
        end
`endif
        RST = 1'b0;
        tick();
    endtask

    task automatic test_de_before_vsync();
        iLINE_READY = 1'b1;
        rand_pixels(20);
        drive_line(20, 1'b0);
        checks++;
        if (oLINE_VALID !== 1'b0 || oV_ADDR !== '0) begin
            failures++;
            $display("FAIL idle_de got=val%0b/v%0d exp=val0/v0", oLINE_VALID, oV_ADDR);
        end
    endtask

    task automatic test_basic_pattern();
        frame_start();
        for (int k = 0; k < 2; k++) begin
            thr = 128;
            for (int i = 0; i < HA; i++) pix[i] = (i % 2 == 0) ? 200 : 10;
            drive_line(HA, 1'b1);
            checks++;
            if (oLINE_VALID !== 1'b1 || oLINE_NUM !== AW'(k)) begin
                failures++;
                $display("FAIL basic_valid_num got=val%0b/n%0d exp=val1/n%0d", oLINE_VALID, oLINE_NUM, k);
            end
            checks++;
            if (oLINE_DATA !== exp_word) begin
                failures++;
                $display("FAIL basic_data got=%h exp=%h", oLINE_DATA, exp_word);
            end
`ifdef VIDEO_CAP_PIXCNT_EN
            checks++;
            if (oLINE_ONES !== AW'(exp_ones)) begin
                failures++;
                $display("FAIL basic_ones got=%0d exp=%0d", oLINE_ONES, exp_ones);
            end
`endif
            tick();
            checks++;
            if (oLINE_VALID !== 1'b0) begin
                failures++;
                $display("FAIL basic_valid_width got=%0b exp=0", oLINE_VALID);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        frame_start();
        iLINE_READY = 1'b0;
        n = $urandom_range(50, HA);
        rand_pixels(n);
        drive_line(n, 1'b1);
        saved_word = exp_word;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (oLINE_VALID !== 1'b1 || oLINE_NUM !== '0 || oLINE_DATA !== saved_word) begin
            failures++;
            $display("FAIL bp_hold got=val%0b/n%0d/%h exp=val1/n0/%h", oLINE_VALID, oLINE_NUM, oLINE_DATA, saved_word);
        end
        n = $urandom_range(50, HA);
        rand_pixels(n);
        drive_line(n, 1'b1);
        checks++;
        if (oLINE_VALID !== 1'b1 || oLINE_NUM !== '0 || oLINE_DATA !== saved_word) begin
            failures++;
            $display("FAIL bp_held_after_drop got=val%0b/n%0d/%h exp=val1/n0/%h", oLINE_VALID, oLINE_NUM, oLINE_DATA, saved_word);
        end
        checks++;
        if (oOVERRUN !== 1'b1) begin
            failures++;
            $display("FAIL bp_overrun got=%0b exp=1", oOVERRUN);
        end
        iLINE_READY = 1'b1;
        tick();
        checks++;
        if (oLINE_VALID !== 1'b0) begin
            failures++;
            $display("FAIL bp_transfer got=%0b exp=0", oLINE_VALID);
        end
        frame_start();
        checks++;
        if (oOVERRUN !== 1'b0 || oV_ADDR !== '0) begin
            failures++;
            $display("FAIL bp_overrun_clear got=ov%0b/v%0d exp=ov0/v0", oOVERRUN, oV_ADDR);
        end
    endtask

    task automatic test_short_long();
        frame_start();
        thr = $urandom_range(1, 255);
        for (int i = 0; i < 100; i++) pix[i] = 255;
        drive_line(100, 1'b1);
        checks++;
        if (oLINE_VALID !== 1'b1 || oLINE_DATA !== exp_word) begin
            failures++;
            $display("FAIL short_data got=val%0b/%h exp=val1/%h", oLINE_VALID, oLINE_DATA, exp_word);
        end
        tick();
        rand_pixels(700);
        drive_line(700, 1'b1);
        checks++;
        if (oLINE_VALID !== 1'b1 || oLINE_NUM !== AW'(1) || oLINE_DATA !== exp_word) begin
            failures++;
            $display("FAIL long_data got=val%0b/n%0d/%h exp=val1/n1/%h", oLINE_VALID, oLINE_NUM, oLINE_DATA, exp_word);
        end
`ifdef VIDEO_CAP_PIXCNT_EN
        checks++;
        if (oLINE_ONES !== AW'(exp_ones)) begin
            failures++;
            $display("FAIL long_ones got=%0d exp=%0d", oLINE_ONES, exp_ones);
        end
`endif
        checks++;
        if (oH_ADDR !== '0) begin
            failures++;
            $display("FAIL h_addr_clear got=%0d exp=0", oH_ADDR);
        end
        tick();
    endtask

    task automatic test_vsync_abort();
        int n;
        frame_start();
        rand_pixels(301);
        iHSYNC = 1'b1;
        tick();
        iHSYNC = 1'b0;
        iTHRESH = PW'(thr);
        for (int i = 0; i < 301; i++) begin
            iDE = 1'b1;
            iPIX = PW'(pix[i]);
            iVSYNC = (i == 300);
            tick();
        end
        checks++;
        if (oFRAME_START !== 1'b1) begin
            failures++;
            $display("FAIL abort_frame_start got=%0b exp=1", oFRAME_START);
        end
        iDE = 1'b0;
        tick();
        iVSYNC = 1'b0;
        checks++;
        if (oLINE_VALID !== 1'b0 || oV_ADDR !== '0) begin
            failures++;
            $display("FAIL abort_no_publish got=val%0b/v%0d exp=val0/v0", oLINE_VALID, oV_ADDR);
        end
        n = $urandom_range(10, 200);
        rand_pixels(n);
        drive_line(n, 1'b1);
        checks++;
        if (oLINE_VALID !== 1'b1 || oLINE_NUM !== '0 || oLINE_DATA !== exp_word) begin
            failures++;
            $display("FAIL abort_next_line got=val%0b/n%0d/%h exp=val1/n0/%h", oLINE_VALID, oLINE_NUM, oLINE_DATA, exp_word);
        end
        tick();
    endtask

    task automatic test_single_pixel();
        frame_start();
        for (int j = 0; j < 2; j++) begin
            thr = 128;
            pix[0] = j ? $urandom_range(128, 255) : $urandom_range(0, 127);
            drive_line(1, 1'b1);
            checks++;
            if (oLINE_VALID !== 1'b1 || oLINE_NUM !== AW'(j) || oLINE_DATA !== exp_word) begin
                failures++;
                $display("FAIL single_pixel got=val%0b/n%0d/%h exp=val1/n%0d/%h", oLINE_VALID, oLINE_NUM, oLINE_DATA, j, exp_word);
            end
            tick();
        end
    endtask

    task automatic test_vactive_limit();
        int n;
        frame_start();
        for (int k = 0; k < VA + 2; k++) begin
            n = $urandom_range(1, 4);
            rand_pixels(n);
            drive_line(n, 1'b0);
            checks++;
            if (k < VA) begin
                if (oLINE_VALID !== 1'b1 || oLINE_NUM !== AW'(k) || oLINE_DATA !== exp_word) begin
                    failures++;
                    $display("FAIL vlimit_line%0d got=val%0b/n%0d/%h exp=val1/n%0d/%h", k, oLINE_VALID, oLINE_NUM, oLINE_DATA, k, exp_word);
                end
            end else if (oLINE_VALID !== 1'b0) begin
                failures++;
                $display("FAIL vlimit_extra%0d got=val%0b exp=val0", k, oLINE_VALID);
            end
            tick();
        end
        checks++;
        if (oOVERRUN !== 1'b0 || oV_ADDR !== AW'(VA)) begin
            failures++;
            $display("FAIL vlimit_end got=ov%0b/v%0d exp=ov0/v%0d", oOVERRUN, oV_ADDR, VA);
        end
    endtask

    task automatic test_ones37();
        int cnt, idx;
        frame_start();
        thr = $urandom_range(1, 255);
        for (int i = 0; i < HA; i++) pix[i] = $urandom_range(0, thr - 1);
        cnt = 0;
        while (cnt < 37) begin
            idx = $urandom_range(0, HA - 1);
            if (pix[idx] < thr) begin
                pix[idx] = $urandom_range(thr, 255);
                cnt++;
            end
        end
        drive_line(HA, 1'b1);
        checks++;
        if (oLINE_VALID !== 1'b1 || oLINE_DATA !== exp_word) begin
            failures++;
            $display("FAIL ones37_data got=val%0b/%h exp=val1/%h", oLINE_VALID, oLINE_DATA, exp_word);
        end
`ifdef VIDEO_CAP_PIXCNT_EN
        checks++;
        if (oLINE_ONES !== AW'(37)) begin
            failures++;
            $display("FAIL ones37_count got=%0d exp=37", oLINE_ONES);
        end
`endif
        tick();
    endtask

    task automatic test_reset_midline();
        frame_start();
        iLINE_READY = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rand_pixels(60);
            drive_line(60, 1'b0);
        end
        iHSYNC = 1'b1;
        tick();
        iHSYNC = 1'b0;
        for (int i = 0; i < 50; i++) begin
            iDE = 1'b1;
            iPIX = 8'hff;
            tick();
        end
        checks++;
        if (oLINE_VALID !== 1'b1 || oOVERRUN !== 1'b1 || oH_ADDR !== AW'(49)) begin
            failures++;
            $display("FAIL pre_reset_state got=val%0b/ov%0b/h%0d exp=val1/ov1/h49", oLINE_VALID, oOVERRUN, oH_ADDR);
        end
        RST = 1'b1;
        tick();
        checks++;
        if ({oH_ADDR, oV_ADDR, oLINE_NUM, oLINE_VALID, oFRAME_START, oOVERRUN} !== '0 || oLINE_DATA !== '0) begin
            failures++;
            $display("FAIL midline_reset got=h%0h/v%0h/n%0h/val%0b/fs%0b/ov%0b exp=0", oH_ADDR, oV_ADDR, oLINE_NUM, oLINE_VALID, oFRAME_START, oOVERRUN);
        end
`ifdef VIDEO_CAP_PIXCNT_EN
        checks++;
        if (oLINE_ONES !== '0) begin
            failures++;
            $display("FAIL midline_reset_ones got=%0d exp=0", oLINE_ONES);
        end
`endif
        RST = 1'b0;
        iDE = 1'b0;
        iLINE_READY = 1'b1;
        tick();
        tick();
        checks++;
        if (oLINE_VALID !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_publish got=%0b exp=0", oLINE_VALID);
        end
    endtask

    initial begin
        test_reset();
        test_de_before_vsync();
        test_basic_pattern();
        test_backpressure();
        test_short_long();
        test_vsync_abort();
        test_single_pixel();
        test_vactive_limit();
        test_ones37();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/video_line_capture.md
Name: video_line_capture

Overview:
Input-side counterpart of the VGA test-pattern/output stage. It receives raw camera video (VSYNC/HSYNC/DE plus pixel), generates the H/V pixel addresses, and binarizes each pixel against a threshold. Each active line is packed into one HACTIVE-bit word and handed to the line-memory writer over a valid/ready handshake. Its output words are the same format as the line-memory words consumed by the VGA output path (bit h = pixel at column h).

Parameters:
ADDR_WIDTH, 11, width of H/V address and line-number outputs
HACTIVE, 640, active pixels per line; packed line word width
VACTIVE, 480, active lines per frame; lines beyond this are discarded
PIXEL_WIDTH, 8, input pixel width

Ports:
VCLK  in  1  pixel clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
iVSYNC  in  1  vertical sync, active-high
iHSYNC  in  1  horizontal sync, active-high; used only for the oH_ADDR clear
iDE  in  1  data enable, active-high
iPIX  in  PIXEL_WIDTH  luminance pixel, valid when iDE=1
iTHRESH  in  PIXEL_WIDTH  binarization threshold, sampled on every DE pixel
oH_ADDR  out  ADDR_WIDTH  column of the pixel currently sampled
oV_ADDR  out  ADDR_WIDTH  line index of the current active line
oLINE_DATA  out  HACTIVE  packed binarized line; stable while oLINE_VALID=1
oLINE_NUM  out  ADDR_WIDTH  line index of oLINE_DATA
oLINE_VALID  out  1  line word available
iLINE_READY  in  1  consumer accepts the word
oFRAME_START  out  1  one-cycle pulse on VSYNC rising edge
oOVERRUN  out  1  sticky: a completed line was dropped; cleared at frame start

Behaviour:
- Reset: every output is 0; state IDLE; internal counters 0.
- Edge detection: registered copies of iVSYNC and iDE. VSYNC rise is iVSYNC=1 with previous value 0. DE fall is iDE=0 with previous value 1.
- FSM states: IDLE, WAIT_LINE, ACTIVE.
  - IDLE -> WAIT_LINE on VSYNC rise.
  - WAIT_LINE -> ACTIVE on iDE=1.
  - ACTIVE -> WAIT_LINE on DE fall.
  - Any state -> WAIT_LINE on VSYNC rise. This rule has priority: a partial line is discarded, V count is cleared, and oOVERRUN is cleared.
- oFRAME_START pulses for exactly one cycle, the cycle after a VSYNC rise is sampled.
- Pixel capture in ACTIVE, or on the WAIT_LINE->ACTIVE cycle:
  - bit[h] = (iPIX >= iTHRESH).
  - h increments per DE pixel and saturates at HACTIVE; pixels with h >= HACTIVE are ignored.
  - Shift register bits not written in the line are 0.
- oH_ADDR = h registered; it is cleared on iHSYNC=1 or when iDE=0.
- Line publish: on the DE fall cycle, if V count < VACTIVE, the line is published. The publish edge is the first edge that samples iDE=0, so latency is 1 cycle after the last pixel edge.
  - If oLINE_VALID=0, or (oLINE_VALID=1 and iLINE_READY=1) in the same cycle: load oLINE_DATA and oLINE_NUM, and oLINE_VALID=1 after that edge.
  - Otherwise the line is dropped and oOVERRUN=1.
- V count increments on every DE fall, saturating at VACTIVE. oV_ADDR follows V count.
- Handshake:
  - Transfer occurs on an edge where oLINE_VALID=1 and iLINE_READY=1.
  - oLINE_VALID clears after the transfer unless a new line loads in the same cycle.
  - oLINE_DATA and oLINE_NUM must not change while oLINE_VALID=1 and iLINE_READY=0.
- Zero-length DE (one cycle high): publishes a word with only bit 0 possibly set.
- DE before the first VSYNC (state IDLE): ignored.

Optional Feature:
Macro VIDEO_CAP_PIXCNT_EN.
- Defined: adds output oLINE_ONES [ADDR_WIDTH], the count of 1 bits in the published line.
  - Accumulated in step with capture, saturating at HACTIVE.
  - Loaded together with oLINE_DATA and held under the same handshake rules.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package video_cap_pkg holds:
  - FSM state enum (IDLE, WAIT_LINE, ACTIVE).
  - Default geometry constants (HACTIVE 640, VACTIVE 480).
  - Address width constant.
- One sub-module, sync_edge_det: registered rise/fall detector, instantiated for iVSYNC and iDE.
- The packer, counters, and handshake stay in the top module.

Test Plan:
- Reset, then frame with 2 lines of 640 pixels, iPIX=200 on even columns and 10 on odd, iTHRESH=128, iLINE_READY=1 -> two words, pattern 0x...5555 (bit 0 set), oLINE_NUM 0 then 1, oLINE_VALID high for 1 cycle each, 1 cycle after the last pixel.
- iLINE_READY=0 through line 0 and line 1 -> line 0 word held unchanged, line 1 dropped, oOVERRUN=1. Next VSYNC rise -> oOVERRUN=0, oFRAME_START pulse.
- Short line of 100 pixels all 255 -> bits 0..99=1, bits 100..639=0. Long line of 700 pixels -> only 640 captured, oH_ADDR saturates at 640.
- VSYNC rise at pixel 300 of a line -> no word published, next line has oLINE_NUM=0.
- 482 DE lines in one frame -> exactly 480 words published (oLINE_NUM 0..479), lines 480 and 481 ignored, oOVERRUN stays 0.
- With VIDEO_CAP_PIXCNT_EN, line with 37 pixels >= threshold -> oLINE_ONES=37 alongside the word. Assert RST mid-line -> all outputs 0 next cycle, state IDLE, no publish.
